// File: rtl/uart_rx_if.sv
// Serial receive bundle between the line side (pad + baud generator)
// and the UART receiver. The receiver takes the slave view; the driver
// of the pad/tick and the consumer of received bytes take the master view.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 baud_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output baud_tick,
      output rx,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  baud_tick,
      input  rx,
      output rx_data,
      output rx_valid,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, N data bits, no parity, one stop bit, LSB first.
// Works from an oversampling enable (OVERSAMPLE ticks per bit): the start
// bit is confirmed half a bit after the falling edge, every following bit
// is sampled one full bit period later, i.e. at its centre. Good frames
// update rx_data with a one-cycle rx_valid pulse; a low stop bit gives a
// one-cycle frame_err pulse instead and leaves rx_data untouched.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic    clk,
   input  logic    rst,
   uart_rx_if.slave bus
);

   // Two flops bring the asynchronous line into the clk domain.
   localparam int SYNC_STAGES = 2;
   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Tick index of the start-bit centre, and of the last tick in a bit.
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rx_prev_reg;
   logic                   rx_s;
   logic                   fall_edge;

   state_t                 state_reg;
   logic [TICK_W-1:0]      tick_cnt_reg;
   logic [BIT_W-1:0]       bit_cnt_reg;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [DATA_BITS-1:0]   rx_data_reg;
   logic                   rx_valid_reg;
   logic                   frame_err_reg;
   logic                   busy_reg;

   assign rx_s      = sync_reg[SYNC_STAGES-1];
   // A start needs a genuine high-to-low transition; a line that is merely
   // low (break, or still low after a bad stop bit) never opens a frame.
   assign fall_edge = rx_prev_reg & ~rx_s;

   // Synchroniser chain plus one-cycle history of the synchronised line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg    <= '1;
         rx_prev_reg <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[SYNC_STAGES-2:0], bus.rx};
         rx_prev_reg <= rx_s;
      end
   end

   // Frame FSM: counts ticks within a bit, samples at bit centres and
   // produces the registered result pulses together with busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         tick_cnt_reg  <= '0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         // Result pulses last exactly one clk.
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               // Edge detection runs every clk, independent of baud_tick,
               // so a new start bit right after a stop bit is not missed.
               if (fall_edge) begin
                  state_reg    <= START;
                  tick_cnt_reg <= '0;
                  busy_reg     <= 1'b1;
               end
            end

            START: begin
               if (bus.baud_tick) begin
                  if (tick_cnt_reg == TICK_MID) begin
                     tick_cnt_reg <= '0;
                     if (!rx_s) begin
                        // Still low at the centre: a real start bit.
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                     end else begin
                        // Short low pulse: discard silently.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end else begin
                     tick_cnt_reg <= tick_cnt_reg + 1'b1;
                  end
               end
            end

            DATA: begin
               if (bus.baud_tick) begin
                  if (tick_cnt_reg == TICK_LAST) begin
                     // LSB arrives first; shifting in at the top leaves it
                     // in bit 0 once all data bits are in.
                     shift_reg    <= {rx_s, shift_reg[DATA_BITS-1:1]};
                     bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                     tick_cnt_reg <= '0;
                     if (bit_cnt_reg == BIT_LAST) begin
                        state_reg <= STOP;
                     end
                  end else begin
                     tick_cnt_reg <= tick_cnt_reg + 1'b1;
                  end
               end
            end

            STOP: begin
               if (bus.baud_tick) begin
                  if (tick_cnt_reg == TICK_LAST) begin
                     if (rx_s) begin
                        rx_data_reg  <= shift_reg;
                        rx_valid_reg <= 1'b1;
                     end else begin
                        frame_err_reg <= 1'b1;
                     end
                     // Return to IDLE at the stop-bit centre so the next
                     // start edge can follow with no extra idle time.
                     state_reg    <= IDLE;
                     tick_cnt_reg <= '0;
                     busy_reg     <= 1'b0;
                  end else begin
                     tick_cnt_reg <= tick_cnt_reg + 1'b1;
                  end
               end
            end

            default: begin
               state_reg    <= IDLE;
               tick_cnt_reg <= '0;
               busy_reg     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data   = rx_data_reg;
   assign bus.rx_valid  = rx_valid_reg;
   assign bus.frame_err = frame_err_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A transmitter model serialises frames
// onto rx; each frame's expected outcome (byte or framing error) is queued
// when it is sent and matched against the DUT's pulses by a monitor.
module tb_uart_rx;

   localparam int DB = 8;
   localparam int OS = 16;

   typedef struct packed {
      logic          err;
      logic [DB-1:0] data;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   cyc;
   int   tick_div;
   int   bit_clks;
   exp_t exp_q[$];
   int   valid_t[$];
   logic [DB-1:0] model_data;

   uart_rx_if #(.DATA_BITS(DB)) uif ();

   uart_rx #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(uif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Baud tick generator: one pulse every tick_div clks (constant high at 1).
   initial begin
      int cnt;
      cnt = 0;
      uif.baud_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_div <= 1) begin
            uif.baud_tick = 1'b1;
         end else begin
            cnt = cnt + 1;
            if (cnt >= tick_div) cnt = 0;
            uif.baud_tick = (cnt == 0);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_div(input int d);
      tick_div = d;
      bit_clks = OS * ((d < 1) ? 1 : d);
   endtask

   // Transmit one 8N1 frame, LSB first, with the given stop-bit level.
   task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit);
      exp_t e;
      e.err  = ~stop_bit;
      e.data = d;
      exp_q.push_back(e);
      uif.rx = 1'b0;
      wait_clks(bit_clks);
      for (int i = 0; i < DB; i++) begin
         uif.rx = d[i];
         wait_clks(bit_clks);
      end
      uif.rx = stop_bit;
      wait_clks(bit_clks);
   endtask

   // Monitor: every pulse must match the oldest outstanding frame.
   always @(negedge clk) begin
      if (!rst && (uif.rx_valid || uif.frame_err)) begin
         check("pulse_exclusive", 32'(uif.rx_valid & uif.frame_err), 32'd0);
         check("busy_at_pulse", 32'(uif.busy), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind_err", 32'(uif.frame_err), 32'(e.err));
            if (!e.err) begin
               check("rx_data", 32'(uif.rx_data), 32'(e.data));
               model_data = e.data;
               valid_t.push_back(cyc);
               $display("[%0d] rx_valid data=%02h", cyc, uif.rx_data);
            end else begin
               check("data_hold_on_err", 32'(uif.rx_data), 32'(model_data));
               $display("[%0d] frame_err data_held=%02h", cyc, uif.rx_data);
            end
         end
      end
   end

   initial begin
      int t_start;
      int lat;
      logic [DB-1:0] d;
      logic sb;
      int gap;

      n_checks   = 0;
      n_errors   = 0;
      cyc        = 0;
      model_data = '0;
      rst        = 1'b1;
      uif.rx     = 1'b1;
      set_div(54);

      // Reset state
      wait_clks(4);
      check("reset_rx_data", 32'(uif.rx_data), 32'd0);
      check("reset_rx_valid", 32'(uif.rx_valid), 32'd0);
      check("reset_frame_err", 32'(uif.frame_err), 32'd0);
      check("reset_busy", 32'(uif.busy), 32'd0);
      rst = 1'b0;
      wait_clks(100);

      // Single frame 0xA5 at 864 clks/bit, with latency window
      valid_t.delete();
      t_start = cyc;
      send_frame(8'hA5, 1'b1);
      wait_clks(2 * bit_clks);
      check("a5_queue_empty", 32'(exp_q.size()), 32'd0);
      check("a5_busy_after", 32'(uif.busy), 32'd0);
      check("a5_data_held", 32'(uif.rx_data), 32'hA5);
      check("a5_pulse_count", 32'(valid_t.size()), 32'd1);
      if (valid_t.size() > 0) begin
         lat = valid_t[0] - t_start;
         check("a5_latency_window", 32'((lat >= 8150) && (lat <= 8215)), 32'd1);
      end

      // Three back-to-back frames, no idle bits
      valid_t.delete();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      wait_clks(2 * bit_clks);
      check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
      check("b2b_pulse_count", 32'(valid_t.size()), 32'd3);
      if (valid_t.size() == 3) begin
         check("b2b_spacing_1", 32'(valid_t[1] - valid_t[0]), 32'd8640);
         check("b2b_spacing_2", 32'(valid_t[2] - valid_t[1]), 32'd8640);
      end

      // Glitch shorter than half a bit
      uif.rx = 1'b0;
      wait_clks(100);
      check("glitch_busy_during", 32'(uif.busy), 32'd1);
      wait_clks(200);
      uif.rx = 1'b1;
      wait_clks(200);
      check("glitch_busy_after", 32'(uif.busy), 32'd0);
      check("glitch_no_pulse", 32'(exp_q.size()), 32'd0);
      check("glitch_data_held", 32'(uif.rx_data), 32'h3C);

      // Framing error: 0x55 with low stop, line held low two more bits
      set_div(4);
      wait_clks(3 * bit_clks);
      send_frame(8'h55, 1'b0);
      wait_clks(bit_clks);
      check("ferr_reported", 32'(exp_q.size()), 32'd0);
      check("ferr_no_restart", 32'(uif.busy), 32'd0);
      check("ferr_data_held", 32'(uif.rx_data), 32'h3C);
      wait_clks(bit_clks);
      uif.rx = 1'b1;
      wait_clks(2 * bit_clks);
      check("ferr_idle_busy", 32'(uif.busy), 32'd0);

      // Reset during bit 4 of 0x81; transmitter abandons the frame
      d = 8'h81;
      uif.rx = 1'b0;
      wait_clks(bit_clks);
      for (int i = 0; i < 4; i++) begin
         uif.rx = d[i];
         wait_clks(bit_clks);
      end
      uif.rx = d[4];
      wait_clks(bit_clks / 2);
      check("abort_busy_before_rst", 32'(uif.busy), 32'd1);
      rst = 1'b1;
      uif.rx = 1'b1;
      wait_clks(1);
      rst = 1'b0;
      model_data = '0;
      check("abort_rx_data_zero", 32'(uif.rx_data), 32'd0);
      check("abort_busy_zero", 32'(uif.busy), 32'd0);
      wait_clks(12 * bit_clks);
      check("abort_no_pulse", 32'(exp_q.size()), 32'd0);
      check("abort_data_still_zero", 32'(uif.rx_data), 32'd0);
      send_frame(8'h81, 1'b1);
      wait_clks(2 * bit_clks);
      check("clean_81_done", 32'(exp_q.size()), 32'd0);
      check("clean_81_data", 32'(uif.rx_data), 32'h81);

      // baud_tick held high: 16 clks per bit
      set_div(1);
      wait_clks(3 * bit_clks);
      send_frame(8'h96, 1'b1);
      wait_clks(2 * bit_clks);
      check("tick_high_done", 32'(exp_q.size()), 32'd0);
      check("tick_high_data", 32'(uif.rx_data), 32'h96);

      // Randomized frames at two tick rates, occasional bad stop bits
      for (int pass = 0; pass < 2; pass++) begin
         set_div((pass == 0) ? 4 : 1);
         wait_clks(3 * bit_clks);
         for (int n = 0; n < 12; n++) begin
            d  = DB'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            send_frame(d, sb);
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
            uif.rx = 1'b1;
            wait_clks(gap * bit_clks);
         end
         uif.rx = 1'b1;
         wait_clks(2 * bit_clks);
         check("rand_all_received", 32'(exp_q.size()), 32'd0);
         check("rand_busy_idle", 32'(uif.busy), 32'd0);
         check("rand_data_model", 32'(uif.rx_data), 32'(model_data));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the 16x oversampling tick from the baud generator.
- Samples the asynchronous serial line `rx` at mid-bit and deserialises 8N1 frames, LSB first.
- Presents each byte with a one-cycle valid pulse, or flags a framing error.
- Sits between the pad and the RX FIFO / host logic, in the same clock domain as the baud generator.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9 legal).
- OVERSAMPLE, 16, baud_tick pulses per bit period; must match the baud generator's BAUD multiplier.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  single-cycle enable, OVERSAMPLE per bit period, from the baud generator.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE. Synchroniser flops and rx_prev reset to 1; tick counter and bit counter reset to 0.
- Synchronisation:
  - rx passes through 2 flops to produce rx_s; rx_prev is rx_s delayed one clk.
  - All decisions use rx_s only.
  - A falling edge is rx_prev=1 and rx_s=0, evaluated every clk (not gated by baud_tick).
- Tick counter (tick_cnt, width clog2(OVERSAMPLE)) advances only on clk edges where baud_tick=1. It is cleared on every state entry.
- IDLE:
  - On a falling edge, go to START with tick_cnt=0, busy=1.
  - A level-low line with no preceding high (e.g. break, or a line still low after a framing error) does not start a frame.
- START:
  - On the baud_tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: glitch; return to IDLE with no output pulse.
- DATA:
  - On the baud_tick where tick_cnt==OVERSAMPLE-1, shift rx_s into a shift register at the MSB end (right shift, so the first bit ends at bit 0), increment bit_cnt, and clear tick_cnt.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: on the baud_tick where tick_cnt==OVERSAMPLE-1:
  - rx_s=1: rx_data <= shift register and rx_valid=1 on the next clk.
  - rx_s=0: frame_err=1 on the next clk; rx_data unchanged.
  - Either way, go to IDLE; busy falls in the same cycle the pulse is asserted.
- Pulses are registered, exactly one clk wide, and never both high at once.
- Latency: rx_valid rises 1 clk after the baud_tick that samples the stop bit. That is ≈ (DATA_BITS+1.5)*OVERSAMPLE ticks after the start edge, plus 2–3 clks of synchroniser delay.
- Back-to-back frames: a falling edge in the cycle after returning to IDLE is accepted; no extra idle time is required.
- baud_tick held high continuously is legal: the counter advances every clk.
- rst asserted mid-frame aborts the frame on the next clk. No pulse is generated and rx_data is cleared to 0.
- rx transitions between sample points are ignored; there is no majority voting.

Test Plan:
- CLK_FREQ=100 MHz, tick every 54 clks (864 clks/bit). Send 0xA5 8N1 → exactly one rx_valid pulse with rx_data=0xA5, frame_err=0, busy low afterwards.
- Send 0x00, then 0xFF, then 0x3C back-to-back with zero idle bits → three rx_valid pulses with data 0x00, 0xFF, 0x3C in order, spaced 10 bit times (8640 clks) apart.
- Pull rx low for 300 clks (under half a bit), then high → no rx_valid, no frame_err, state back in IDLE (busy=0) by ~432 clks after the edge.
- Send 0x55 with the stop bit driven low, then hold rx low for 2 bit times, then high → one frame_err pulse, rx_data keeps its previous value, and no new frame starts until the next high-to-low edge.
- Assert rst for 1 clk during bit 4 of a 0x81 frame, then send 0x81 cleanly → the aborted frame produces no pulse, rx_data=0 after reset, and the clean frame yields rx_valid with 0x81.
- Hold baud_tick=1 constantly (OVERSAMPLE clks/bit) and send 0x96 at 16 clks/bit → rx_valid with rx_data=0x96.
